trigger_conditioner: RTL
========================

# trigger_conditioner

Conditions a raw external trigger into a clean one-cycle trigger pulse. It sits directly upstream of the feedback-path triggered gate and drives that gate's trigger input. The raw input is synchronised and edge-detected. Triggers can be decimated by N, and further edges are blocked for a programmable holdoff window after each emitted trigger, so one emitted pulse starts exactly one gate window.

## Interface
- `COUNTER_WIDTH`, default 18: width of the holdoff counter; matches the gate's delay/toggle counters.
- `DIV_WIDTH`, default 8: width of the trigger divider.
- `CNT_WIDTH`, default 16: width of the emitted-trigger counter.

Ports:
- `clk_i`  in  1  sole clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `trig_raw_i`  in  1  raw trigger, asynchronous to `clk_i`.
- `arm_i`  in  1  1 = accept triggers, 0 = disarmed.
- `edge_sel_i`  in  1  0 = rising edge, 1 = falling edge.
- `divider_i`  in  DIV_WIDTH  emit on every Nth accepted edge; 0 is treated as 1.
- `holdoff_cycles_i`  in  COUNTER_WIDTH  dead time after each emitted trigger.
- `trig_o`  out  1  one-cycle trigger pulse to the gate.
- `busy_o`  out  1  high while in HOLDOFF.
- `trig_count_o`  out  CNT_WIDTH  count of emitted triggers.

## Operation
- **Synchroniser:** two flops, s1 then s2, on `trig_raw_i`. A third flop s3 holds the previous s2.
- **Edge detect:**
  - rising: `edge = s2 & ~s3`
  - falling: `edge = ~s2 & s3`
  - `edge_sel_i` is sampled combinationally. A change mid-level does not create an edge.
- **States:**
  - IDLE:
    - `arm_i` = 1 -> ARMED.
    - Edges are ignored.
    - Divider count is held at 0.
  - ARMED:
    - Each edge increments the divider count `div_cnt`.
    - When `div_cnt + 1 >= max(divider_i, 1)`: assert `trig_o` next cycle, clear `div_cnt`, latch `holdoff_cycles_i` into `hold_cnt`, go to HOLDOFF.
    - If the latched holdoff is 0, go back to ARMED instead of HOLDOFF.
  - HOLDOFF:
    - `hold_cnt` decrements every cycle. Edges are ignored and not counted.
    - Leave to ARMED on the cycle `hold_cnt` reaches 1 → 0 transition completes (see Timing).
  - Any state: `arm_i` = 0 -> IDLE next cycle. This aborts holdoff and clears `div_cnt` and `hold_cnt`. A pending `trig_o` already registered still completes.
- **Emitted-trigger counter:** `trig_count_o` increments by 1 on each `trig_o` cycle. It wraps from 2^CNT_WIDTH−1 to 0 and is cleared only by `rst_i`.
- **Parameter sampling:** `divider_i` is used live. `holdoff_cycles_i` is sampled only at the trigger cycle; later changes affect only the next holdoff.
- **Arming with a held level:** arming while the input is already at the active level gives no trigger; only a true edge after arming counts.
- **Reset:** drives all flops to 0. Outputs during and after reset: `trig_o` = 0, `busy_o` = 0, `trig_count_o` = 0, state = IDLE. s1/s2/s3 are reset to 0, so a raw input high at reset release yields one rising edge 2 cycles later. That edge is accepted only if armed.

## Timing
- **Latency:** `trig_raw_i` first sampled at its new level at edge k -> `trig_o` high for exactly the cycle after edge k+3. This is 3 cycles without deglitch, 5 with deglitch.
- **`trig_o` width:** exactly 1 cycle, never back-to-back. With holdoff 0 the minimum spacing is set by edge-detect spacing: at least 2 cycles for alternating input.
- **`busy_o`:** high for exactly H = `holdoff_cycles_i` cycles, starting the cycle after `trig_o`. An edge detected on the first cycle `busy_o` is low is accepted.
- **Simultaneous edge and `arm_i` falling:** disarm wins; no trigger and no count.
- **Simultaneous divider hit and `arm_i` rising from IDLE:** impossible by construction, because IDLE always counts from 0.

## Configuration
- `TRIG_COND_DEGLITCH_EN` defined:
  - A pipeline holds the last 3 s2 samples.
  - An edge is declared only when the pre-edge level was stable for 1 sample and the new level is stable for 3 consecutive samples.
  - Pulses shorter than 3 cycles are rejected.
  - Latency is +2 cycles.
- Not defined: edge detection acts directly on s2/s3; any level held for at least 1 sample produces an edge.

## Test plan
- **Single rising edge:** reset, `arm_i`=1, `divider_i`=1, holdoff 0, raw 0→1 at edge 10 -> one `trig_o` pulse after edge 13 (15 with deglitch); `trig_count_o`=1.
- **Divider:** `divider_i`=4, 10 clean edges -> `trig_o` on the 4th and 8th edges only; `trig_count_o`=2. Repeat with `divider_i`=0 -> 10 pulses.
- **Holdoff:** holdoff 100, edges every 30 cycles -> trigger, then edges during `busy_o` ignored; `busy_o` high exactly 100 cycles; the next trigger comes from the first edge after `busy_o` falls.
- **Disarm during holdoff:** `arm_i`=0 at holdoff cycle 20 -> `busy_o`=0 next cycle; no triggers while disarmed. Re-arm with input held high -> no trigger until the next true edge.
- **Falling edge and wrap:** `edge_sel_i`=1, CNT_WIDTH=4 overridden, 17 falling edges -> triggers only on falling edges; `trig_count_o` reads 1 after wrap.
- **Glitch (deglitch build):** 1- and 2-cycle raw pulses -> no trigger; 3-cycle pulse -> one trigger. In the non-deglitch build, a 1-cycle pulse -> one trigger.

Source files
------------

// File: rtl/trigger_conditioner.sv
// Turns an asynchronous raw trigger into a clean one-cycle pulse: sync, edge select, divide, holdoff.
// Build option: define TRIG_COND_DEGLITCH_EN to require a 3-sample stable level before an edge counts.
module trigger_conditioner #(
   parameter int COUNTER_WIDTH = 18,
   parameter int DIV_WIDTH     = 8,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     trig_raw_i,
   input  logic                     arm_i,
   input  logic                     edge_sel_i,
   input  logic [DIV_WIDTH-1:0]     divider_i,
   input  logic [COUNTER_WIDTH-1:0] holdoff_cycles_i,
   output logic                     trig_o,
   output logic                     busy_o,
   output logic [CNT_WIDTH-1:0]     trig_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   localparam logic [DIV_WIDTH-1:0]     DIV_ONE     = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH:0]       DIV_ONE_EXT = (DIV_WIDTH + 1)'(1);
   localparam logic [COUNTER_WIDTH-1:0] HOLD_ONE    = COUNTER_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]     CNT_ONE     = CNT_WIDTH'(1);

   logic                     r_s1;
   logic                     r_s2;
   logic                     r_s3;
   logic                     w_rise;
   logic                     w_fall;
   logic                     w_edge;
   logic                     r_edge;
   state_t                   r_state;
   logic [DIV_WIDTH-1:0]     r_div_cnt;
   logic [COUNTER_WIDTH-1:0] r_hold_cnt;
   logic                     r_trig;
   logic                     r_busy;
   logic [CNT_WIDTH-1:0]     r_trig_cnt;
   logic [DIV_WIDTH-1:0]     w_div_eff;
   logic [DIV_WIDTH:0]       w_div_next;
   logic                     w_div_hit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= trig_raw_i;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

`ifdef TRIG_COND_DEGLITCH_EN
   logic r_s4;
   logic r_s5;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s4 <= 1'b0;
         r_s5 <= 1'b0;
      end else begin
         r_s4 <= r_s3;
         r_s5 <= r_s4;
      end
   end

   // New level must hold in s2..s4 with the opposite level one sample before it.
   assign w_rise = r_s2 & r_s3 & r_s4 & ~r_s5;
   assign w_fall = ~r_s2 & ~r_s3 & ~r_s4 & r_s5;
`else
   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;
`endif

   // Selecting between two level-change detectors means flipping edge_sel on a steady level is harmless.
   assign w_edge = edge_sel_i ? w_fall : w_rise;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_edge <= 1'b0;
      end else begin
         r_edge <= w_edge;
      end
   end

   assign w_div_eff  = (divider_i == '0) ? DIV_ONE : divider_i;
   assign w_div_next = {1'b0, r_div_cnt} + DIV_ONE_EXT;
   assign w_div_hit  = (w_div_next >= {1'b0, w_div_eff});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_div_cnt  <= '0;
         r_hold_cnt <= '0;
         r_trig     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_trig <= 1'b0;
         if (!arm_i) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state   <= ST_ARMED;
                  r_div_cnt <= '0;
                  r_busy    <= 1'b0;
               end
               ST_ARMED: begin
                  r_busy <= 1'b0;
                  if (r_edge) begin
                     if (w_div_hit) begin
                        r_trig     <= 1'b1;
                        r_div_cnt  <= '0;
                        r_hold_cnt <= holdoff_cycles_i;
                        r_state    <= (holdoff_cycles_i == '0) ? ST_ARMED : ST_HOLDOFF;
                     end else begin
                        r_div_cnt <= w_div_next[DIV_WIDTH-1:0];
                     end
                  end
               end
               ST_HOLDOFF: begin
                  // The trigger cycle itself is spent here with busy low, so busy spans exactly H cycles.
                  if (r_hold_cnt == '0) begin
                     r_state <= ST_ARMED;
                     r_busy  <= 1'b0;
                  end else begin
                     r_hold_cnt <= r_hold_cnt - HOLD_ONE;
                     r_busy     <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_trig_cnt <= '0;
      end else if (r_trig) begin
         r_trig_cnt <= r_trig_cnt + CNT_ONE;
      end
   end

   assign trig_o       = r_trig;
   assign busy_o       = r_busy;
   assign trig_count_o = r_trig_cnt;

endmodule
